lora_frame_sequencer: RTL and testbench

Frame-level controller for the LoRa TX chirp datapath. It walks one packet through preamble upchirps, two sync-word upchirps, two downchirps, one quarter downchirp and the payload symbols. For each chirp it drives `chirp_type` into `constant` and counts out `symbol_size` samples, gating the downstream phase accumulator. Payload symbols arrive over a valid/ready handshake.

---
 rtl/lora_frame_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_lora_frame_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lora_frame_sequencer.sv
// LoRa TX frame sequencer: walks preamble, sync, downchirps, quarter downchirp and payload,
// counting out symbol_size samples per chirp to gate the chirp datapath.
module lora_frame_sequencer #(
   parameter int PRECISION       = 16,
   parameter int SYM_W           = 12,
   parameter int CNT_W           = PRECISION,
   parameter int CHIRP_TYPE_SIZE = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [7:0]                 preamble_len,
   input  logic [7:0]                 sync_word,
   input  logic [7:0]                 payload_len,
   input  logic [CNT_W-1:0]           symbol_size,
   input  logic [SYM_W-1:0]           sym_data,
   input  logic                       sym_valid,
   output logic                       sym_ready,
   output logic [CHIRP_TYPE_SIZE-1:0] chirp_type,
   output logic [SYM_W-1:0]           symbol_val,
   output logic                       sample_en,
   output logic                       chirp_start,
   output logic                       busy,
   output logic                       done
);

   localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_UPCHIRP     = CHIRP_TYPE_SIZE'(0);
   localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_DOWNCHIRP   = CHIRP_TYPE_SIZE'(1);
   localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_Q_DOWNCHIRP = CHIRP_TYPE_SIZE'(2);

   typedef enum logic [1:0] {IDLE, FETCH, SETUP, RUN} state_t;
   typedef enum logic [2:0] {SEG_PRE, SEG_SYNC, SEG_DOWN, SEG_QDOWN, SEG_PAY} seg_t;

   state_t                     state, state_d;
   seg_t                       seg, seg_d, nxt_seg;
   logic [7:0]                 idx, idx_d, nxt_idx;
   logic                       nxt_end;
   logic                       setup_cnt, setup_cnt_d;
   logic [CNT_W-1:0]           cnt, cnt_d;
   logic [7:0]                 n_lat, n_lat_d, sw_lat, sw_lat_d, p_lat, p_lat_d;
   logic [CHIRP_TYPE_SIZE-1:0] chirp_type_d;
   logic [SYM_W-1:0]           symbol_val_d;
   logic                       sample_en_d, chirp_start_d, sym_ready_d, busy_d, done_d;

   function automatic logic [CHIRP_TYPE_SIZE-1:0] type_of(input seg_t s);
      case (s)
         SEG_DOWN:  type_of = TYPE_DOWNCHIRP;
         SEG_QDOWN: type_of = TYPE_Q_DOWNCHIRP;
         default:   type_of = TYPE_UPCHIRP;
      endcase
   endfunction

   function automatic logic [SYM_W-1:0] val_of(input seg_t s, input logic [7:0] i,
                                               input logic [7:0] sw);
      val_of = '0;
      if (s == SEG_SYNC)
         val_of = (i == 8'd0) ? SYM_W'({sw[7:4], 3'b000}) : SYM_W'({sw[3:0], 3'b000});
   endfunction

   // Successor of the current chirp; nxt_end marks the last chirp of the frame
   always_comb begin
      nxt_seg = seg;
      nxt_idx = idx + 8'd1;
      nxt_end = 1'b0;
      case (seg)
         SEG_PRE: begin
            if (idx == n_lat - 8'd1) begin
               nxt_seg = SEG_SYNC;
               nxt_idx = 8'd0;
            end
         end
         SEG_SYNC: begin
            if (idx != 8'd0) begin
               nxt_seg = SEG_DOWN;
               nxt_idx = 8'd0;
            end
         end
         SEG_DOWN: begin
            if (idx != 8'd0) begin
               nxt_seg = SEG_QDOWN;
               nxt_idx = 8'd0;
            end
         end
         SEG_QDOWN: begin
            nxt_seg = SEG_PAY;
            nxt_idx = 8'd0;
            nxt_end = (p_lat == 8'd0);
         end
         SEG_PAY:  nxt_end = (idx == p_lat - 8'd1);
         default:  nxt_end = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state;
      seg_d         = seg;
      idx_d         = idx;
      setup_cnt_d   = setup_cnt;
      cnt_d         = cnt;
      n_lat_d       = n_lat;
      sw_lat_d      = sw_lat;
      p_lat_d       = p_lat;
      chirp_type_d  = chirp_type;
      symbol_val_d  = symbol_val;
      busy_d        = busy;
      sample_en_d   = 1'b0;
      chirp_start_d = 1'b0;
      sym_ready_d   = 1'b0;
      done_d        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               n_lat_d      = preamble_len;
               sw_lat_d     = sync_word;
               p_lat_d      = payload_len;
               busy_d       = 1'b1;
               seg_d        = (preamble_len != 8'd0) ? SEG_PRE : SEG_SYNC;
               idx_d        = 8'd0;
               chirp_type_d = TYPE_UPCHIRP;
               symbol_val_d = val_of(seg_d, 8'd0, sync_word);
               setup_cnt_d  = 1'b0;
               state_d      = SETUP;
            end
         end
         FETCH: begin
            sym_ready_d = 1'b1;
            if (sym_valid && sym_ready) begin
               symbol_val_d = sym_data;
               sym_ready_d  = 1'b0;
               setup_cnt_d  = 1'b0;
               state_d      = SETUP;
            end
         end
         SETUP: begin
            // second gap cycle: symbol_size now reflects the new chirp_type
            if (!setup_cnt) begin
               setup_cnt_d = 1'b1;
            end else begin
               cnt_d         = (symbol_size == '0) ? '0 : symbol_size - CNT_W'(1);
               sample_en_d   = 1'b1;
               chirp_start_d = 1'b1;
               state_d       = RUN;
            end
         end
         RUN: begin
            if (cnt != '0) begin
               cnt_d       = cnt - CNT_W'(1);
               sample_en_d = 1'b1;
            end else if (nxt_end) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               seg_d        = nxt_seg;
               idx_d        = nxt_idx;
               chirp_type_d = type_of(nxt_seg);
               if (nxt_seg == SEG_PAY) begin
                  sym_ready_d = 1'b1;
                  state_d     = FETCH;
               end else begin
                  symbol_val_d = val_of(nxt_seg, nxt_idx, sw_lat);
                  setup_cnt_d  = 1'b0;
                  state_d      = SETUP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         seg         <= SEG_PRE;
         idx         <= 8'd0;
         setup_cnt   <= 1'b0;
         chirp_type  <= TYPE_UPCHIRP;
         symbol_val  <= '0;
         sample_en   <= 1'b0;
         chirp_start <= 1'b0;
         sym_ready   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_d;
         seg         <= seg_d;
         idx         <= idx_d;
         setup_cnt   <= setup_cnt_d;
         chirp_type  <= chirp_type_d;
         symbol_val  <= symbol_val_d;
         sample_en   <= sample_en_d;
         chirp_start <= chirp_start_d;
         sym_ready   <= sym_ready_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      cnt    <= cnt_d;
      n_lat  <= n_lat_d;
      sw_lat <= sw_lat_d;
      p_lat  <= p_lat_d;
   end

endmodule

// File: tb/tb_lora_frame_sequencer.sv
// Bench for lora_frame_sequencer: directed and random frames compared against a
// chirp-list reference model built from the frame parameters.
module tb_lora_frame_sequencer;

   localparam int SYM_W  = 12;
   localparam int CNT_W  = 16;
   localparam int T_UP   = 0;
   localparam int T_DN   = 1;
   localparam int T_QD   = 2;
   localparam int BUDGET = 4000;

   logic             clk = 1'b0;
   logic             rst, start, sym_valid, sym_ready;
   logic [7:0]       preamble_len, sync_word, payload_len;
   logic [CNT_W-1:0] symbol_size, base_size;
   logic [SYM_W-1:0] sym_data, symbol_val;
   logic [1:0]       chirp_type;
   logic             sample_en, chirp_start, busy, done;

   lora_frame_sequencer #(.PRECISION(CNT_W), .SYM_W(SYM_W), .CNT_W(CNT_W),
                          .CHIRP_TYPE_SIZE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .preamble_len(preamble_len),
      .sync_word(sync_word), .payload_len(payload_len), .symbol_size(symbol_size),
      .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .chirp_type(chirp_type), .symbol_val(symbol_val), .sample_en(sample_en),
      .chirp_start(chirp_start), .busy(busy), .done(done));

   always #5 clk = ~clk;

   // Stand-in for the constant block: registers the (quartered) size one edge later
   always_ff @(posedge clk)
      symbol_size <= (chirp_type == 2'(T_QD)) ? (base_size >> 2) : base_size;

   int n_vec = 0, n_bad = 0;
   int obs_type[$], obs_val[$], obs_samp[$];
   int exp_type[$], exp_val[$], exp_samp[$];
   int pay_q[$], gap_q[$];
   int done_cnt = 0, overlap_cnt = 0, cs_wo_se = 0, proto_bad = 0;
   bit frame_over;

   always @(negedge clk) begin
      if (chirp_start) begin
         obs_type.push_back(int'(chirp_type));
         obs_val.push_back(int'(symbol_val));
         obs_samp.push_back(sample_en ? 1 : 0);
      end else if (sample_en && obs_samp.size() > 0) begin
         obs_samp[obs_samp.size()-1] += 1;
      end
      if (chirp_start && !sample_en) cs_wo_se++;
      if (sym_ready && sample_en) overlap_cnt++;
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input int obs, input int want);
      n_vec++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   function automatic int nsamp(input int sz);
      return (sz < 1) ? 1 : sz;
   endfunction

   task automatic add_chirp(input int t, input int v, input int s);
      exp_type.push_back(t);
      exp_val.push_back(v);
      exp_samp.push_back(nsamp(s));
   endtask

   // Frame = N preamble ups, 2 sync ups, 2 downs, 1 quarter down, P payload ups
   task automatic build_model(input int n, input int sw, input int p, input int base);
      exp_type.delete(); exp_val.delete(); exp_samp.delete();
      for (int i = 0; i < n; i++) add_chirp(T_UP, 0, base);
      add_chirp(T_UP, ((sw >> 4) & 15) * 8, base);
      add_chirp(T_UP, (sw & 15) * 8, base);
      add_chirp(T_DN, 0, base);
      add_chirp(T_DN, 0, base);
      add_chirp(T_QD, 0, base / 4);
      for (int i = 0; i < p; i++) add_chirp(T_UP, pay_q[i], base);
   endtask

   task automatic run_frame(input int n, input int sw, input int p, input int base,
                            input int gap_mode, input int fixed_data, input bit mid_start,
                            output int cyc);
      int exp_cyc, c, t;
      pay_q.delete(); gap_q.delete();
      for (int i = 0; i < p; i++) begin
         pay_q.push_back(fixed_data >= 0 ? fixed_data : int'($urandom_range(0, (1 << SYM_W) - 1)));
         gap_q.push_back(gap_mode >= 0 ? gap_mode : int'($urandom_range(0, 3)));
      end
      build_model(n, sw, p, base);
      exp_cyc = 1;
      foreach (exp_samp[i]) exp_cyc += 2 + exp_samp[i];
      foreach (gap_q[i]) exp_cyc += gap_q[i] + 1;
      @(negedge clk);
      base_size = CNT_W'(base);
      @(negedge clk);
      obs_type.delete(); obs_val.delete(); obs_samp.delete();
      done_cnt = 0; overlap_cnt = 0; cs_wo_se = 0; proto_bad = 0; frame_over = 0;
      c = 0;
      preamble_len = 8'(n); sync_word = 8'(sw); payload_len = 8'(p); start = 1'b1;
      fork
         begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            preamble_len = 8'($urandom); sync_word = 8'($urandom); payload_len = 8'($urandom);
            c = 1;
            while (!done && c < BUDGET) begin
               start = (mid_start && c == 6) ? 1'b1 : 1'b0;
               @(negedge clk);
               c++;
            end
            start = 1'b0;
            frame_over = 1;
         end
         begin
            for (int k = 0; k < p && !frame_over; k++) begin
               if (gap_q[k] == 0) begin
                  sym_data = SYM_W'(pay_q[k]); sym_valid = 1'b1;
               end
               t = 0;
               while (!sym_ready && !frame_over && t < BUDGET) begin
                  @(negedge clk); t++;
               end
               if (!sym_ready) break;
               if (gap_q[k] > 0) begin
                  repeat (gap_q[k]) begin
                     @(negedge clk);
                     if (!sym_ready || sample_en) proto_bad++;
                  end
                  sym_data = SYM_W'(pay_q[k]); sym_valid = 1'b1;
               end
               @(negedge clk);
               if (sym_ready) proto_bad++;
               sym_valid = 1'b0;
            end
            sym_valid = 1'b0;
         end
      join
      cyc = c;
      check("done_cycle", c, exp_cyc);
      repeat (4) @(negedge clk);
      check("done_pulses", done_cnt, 1);
      check("busy_after", int'(busy), 0);
      check("ready_sample_overlap", overlap_cnt, 0);
      check("chirp_start_wo_sample", cs_wo_se, 0);
      check("fetch_protocol", proto_bad, 0);
      check("n_chirps", obs_type.size(), exp_type.size());
      for (int i = 0; i < exp_type.size() && i < obs_type.size(); i++) begin
         check($sformatf("type[%0d]", i), obs_type[i], exp_type[i]);
         check($sformatf("val[%0d]", i), obs_val[i], exp_val[i]);
         check($sformatf("samples[%0d]", i), obs_samp[i], exp_samp[i]);
      end
   endtask

   initial begin
      int c, t, tot;
      rst = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_data = '0; base_size = CNT_W'(4);
      preamble_len = 8'd0; sync_word = 8'd0; payload_len = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_chirp_type", int'(chirp_type), T_UP);
      check("rst_symbol_val", int'(symbol_val), 0);
      check("rst_outputs", int'({sample_en, chirp_start, sym_ready, busy, done}), 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset during RUN of preamble chirp 3
      obs_type.delete(); obs_val.delete(); obs_samp.delete();
      preamble_len = 8'd5; sync_word = 8'h9C; payload_len = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (obs_type.size() < 3 && t < BUDGET) begin @(negedge clk); t++; end
      check("rst_run_reached", int'(t < BUDGET), 1);
      repeat (2) @(negedge clk);
      check("pre_rst_sampling", int'(sample_en), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_chirp_type", int'(chirp_type), T_UP);
      check("midrst_symbol_val", int'(symbol_val), 0);
      check("midrst_outputs", int'({sample_en, chirp_start, sym_ready, busy, done}), 0);
      done_cnt = 0;
      repeat (50) @(negedge clk);
      check("midrst_no_done", done_cnt, 0);
      check("midrst_idle", int'(busy), 0);

      // Reset during a stalled FETCH drops the pending symbol
      base_size = CNT_W'(2);
      preamble_len = 8'd0; sync_word = 8'h11; payload_len = 8'd2;
      sym_data = SYM_W'('h321); sym_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!sym_ready && t < BUDGET) begin @(negedge clk); t++; end
      @(negedge clk);
      sym_valid = 1'b0;
      t = 0;
      while (!sym_ready && t < BUDGET) begin @(negedge clk); t++; end
      check("fetch2_reached", int'(t < BUDGET), 1);
      check("fetch2_symbol_val", int'(symbol_val), 'h321);
      sym_data = SYM_W'('h777); sym_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; sym_valid = 1'b0;
      check("fetchrst_symbol_val", int'(symbol_val), 0);
      check("fetchrst_outputs", int'({sample_en, chirp_start, sym_ready, busy, done}), 0);
      done_cnt = 0;
      repeat (20) @(negedge clk);
      check("fetchrst_no_done", done_cnt, 0);

      // Documented frame: N=2, sync 0x34, P=0, S=4
      run_frame(2, 'h34, 0, 4, 0, -1, 1'b0, c);
      check("tp_done_at_40", c, 40);
      tot = 0;
      foreach (obs_samp[i]) tot += obs_samp[i];
      check("tp_total_samples", tot, 25);

      run_frame(0, int'($urandom_range(0, 255)), 1, 3, 0, 'h5A5, 1'b0, c);
      run_frame(1, int'($urandom_range(0, 255)), 2, 3, 10, -1, 1'b0, c);
      run_frame(3, int'($urandom_range(0, 255)), 2, 2, -1, -1, 1'b1, c);
      run_frame(2, int'($urandom_range(0, 255)), 2, 0, -1, -1, 1'b0, c);
      for (int f = 0; f < 6; f++)
         run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 7)), -1, -1,
                   1'($urandom_range(0, 1)), c);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
